// File: rtl/block_data_memory.sv
// Block-granular data memory: the responder on the cache-to-memory interface.
// Serves whole-block reads and write-backs addressed by a block address.
// Every access holds BUSYWAIT high for a fixed latency. Completion is then
// signalled by a single BUSYWAIT-low cycle (DONE), during which the cache
// latches READDATA.
// LATENCY is expected to lie in 1..15 so the load value fits the 4-bit counter.
module block_data_memory #(
    parameter int LATENCY    = 5,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              counter;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic                    req_write;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    access_fire;

    // The access itself happens on the last ACCESS edge, when the counter has run out.
    assign access_fire = (state == ACCESS) && (counter == 4'd0);

    // Sequencer: capture the request in IDLE, count down in ACCESS, then spend one cycle in DONE.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            counter   <= 4'd0;
            req_addr  <= '0;
            req_data  <= '0;
            req_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (READ || WRITE) begin
                        req_addr  <= ADDRESS;
                        req_data  <= WRITEDATA;
                        req_write <= WRITE;
                        counter   <= COUNT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, and written only when a captured write completes.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access_fire && req_write) begin
            mem[req_addr] <= req_data;
        end
    end

    // Read data register: updated only when a read completes, and holds its value otherwise.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            READDATA <= '0;
        end else if (access_fire && !req_write) begin
            READDATA <= mem[req_addr];
        end
    end

    // Busy indication: raised combinationally by a new request in IDLE, and forced low while in reset.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (RESET_N) begin
            case (state)
                IDLE:    BUSYWAIT = READ | WRITE;
                ACCESS:  BUSYWAIT = 1'b1;
                DONE:    BUSYWAIT = 1'b0;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory.
// Expected READDATA values come from a small array model. They are queued when
// each request is issued and compared when BUSYWAIT drops (the DONE cycle).
module tb_block_data_memory;

    localparam int LATENCY = 5;

    logic        CLOCK;
    logic        RESET_N;
    logic        READ;
    logic        WRITE;
    logic [5:0]  ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] modelMem [64];
    logic [31:0] lastRead;
    logic [31:0] expectQ [$];

    block_data_memory #(
        .LATENCY   (LATENCY),
        .ADDR_WIDTH(6),
        .DATA_WIDTH(32)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    // Free-running clock, 10 time-unit period
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison, counted and reported through an immediate assertion
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Model mirrors the reset clearing of the array and of READDATA
    task automatic modelReset();
        foreach (modelMem[i]) modelMem[i] = 32'h0;
        lastRead = 32'h0;
        expectQ.delete();
    endtask

    // Issue one request at a negedge and follow it to its DONE cycle.
    // dropAfter > 0 removes the request (and changes ADDRESS) that many cycles after issue.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [5:0] addr, input logic [31:0] data, input int dropAfter);
        int          cycles;
        logic [31:0] expData;
        @(negedge CLOCK);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = data;
        if (wr) begin
            expectQ.push_back(lastRead);
            modelMem[addr] = data;
        end else begin
            expectQ.push_back(modelMem[addr]);
            lastRead = modelMem[addr];
        end
        #1 checkOutput({tag, " busy on request"}, 32'(BUSYWAIT), 32'd1);
        cycles = 0;
        while (1) begin
            @(negedge CLOCK);
            cycles++;
            if (!BUSYWAIT || cycles > 40) break;
            if (cycles == dropAfter) begin
                READ    = 1'b0;
                WRITE   = 1'b0;
                ADDRESS = 6'h01;
            end
        end
        checkOutput({tag, " busy cycles"}, 32'(cycles), 32'(LATENCY + 1));
        expData = expectQ.pop_front();
        checkOutput({tag, " readdata"}, READDATA, expData);
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    // Directed sequence
    initial begin
        RESET_N   = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 6'h00;
        WRITEDATA = 32'h0;
        modelReset();

        // Reset held two cycles with READ high
        #2 RESET_N = 1'b0;
        READ    = 1'b1;
        ADDRESS = 6'h05;
        repeat (2) @(negedge CLOCK);
        #1;
        checkOutput("reset busywait", 32'(BUSYWAIT), 32'd0);
        checkOutput("reset readdata", READDATA, 32'h0);
        READ = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        applyStimulus("read 05 after reset", 1'b1, 1'b0, 6'h05, 32'h0, 0);

        // Write then read back
        applyStimulus("write 2A", 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 0);
        applyStimulus("read 2A", 1'b1, 1'b0, 6'h2A, 32'h0, 0);

        // Write-back followed by fetch, each a full transaction
        applyStimulus("preload 0B", 1'b0, 1'b1, 6'h0B, 32'hCAFEF00D, 0);
        applyStimulus("writeback 13", 1'b0, 1'b1, 6'h13, 32'h11223344, 0);
        applyStimulus("fetch 0B", 1'b1, 1'b0, 6'h0B, 32'h0, 0);
        applyStimulus("read 13", 1'b1, 1'b0, 6'h13, 32'h0, 0);

        // Request dropped and address changed mid-access
        applyStimulus("dropped read 2A", 1'b1, 1'b0, 6'h2A, 32'h0, 2);

        // Reset in the middle of a write to 3F
        @(negedge CLOCK);
        WRITE     = 1'b1;
        ADDRESS   = 6'h3F;
        WRITEDATA = 32'h12345678;
        #1 checkOutput("midreset busy on request", 32'(BUSYWAIT), 32'd1);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b0;
        #1;
        checkOutput("midreset busywait async", 32'(BUSYWAIT), 32'd0);
        checkOutput("midreset readdata", READDATA, 32'h0);
        WRITE = 1'b0;
        modelReset();
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        #1 checkOutput("after reset idle", 32'(BUSYWAIT), 32'd0);
        applyStimulus("read 3F after reset", 1'b1, 1'b0, 6'h3F, 32'h0, 0);
        applyStimulus("read 2A after reset", 1'b1, 1'b0, 6'h2A, 32'h0, 0);

        // Simultaneous READ and WRITE: write wins, READDATA untouched
        applyStimulus("write 10", 1'b0, 1'b1, 6'h10, 32'h5A5A1234, 0);
        applyStimulus("read 10", 1'b1, 1'b0, 6'h10, 32'h0, 0);
        applyStimulus("read+write 07", 1'b1, 1'b1, 6'h07, 32'hA5A5A5A5, 0);
        applyStimulus("read 07", 1'b1, 1'b0, 6'h07, 32'h0, 0);

        @(negedge CLOCK);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
